// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver: deserialises device-to-host PS/2 frames into bytes with parity/stop error flags
module ps2_mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int GLITCH_FILTER  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READ_ENABLE,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       BYTE_READY,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE
);
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, PARITY = 3'd2, STOP = 3'd3, DONE = 3'd4;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(GLITCH_FILTER) + 1;
  logic [2:0] state;
  logic c_s1, c_s2, d_s1, d_s2, fclk, fclk_q;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic perr, fall, tout;
  assign fall = fclk_q & ~fclk;
  // a stalled frame is abandoned; takes priority over a coincident edge
  assign tout = (state == DATA || state == PARITY || state == STOP) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      {c_s1, c_s2, d_s1, d_s2, fclk, fclk_q} <= '1;
      fcnt <= '0;
      tcnt <= '0;
      shreg <= '0;
      bitcnt <= '0;
      perr <= 1'b0;
      BYTE_READY <= 1'b0;
      BYTE_READ <= '0;
      BYTE_ERROR_CODE <= '0;
    end else begin
      c_s1 <= CLK_MOUSE_IN;
      c_s2 <= c_s1;
      d_s1 <= DATA_MOUSE_IN;
      d_s2 <= d_s1;
      if (c_s2 == fclk) fcnt <= '0;
      else if (fcnt == FW'(GLITCH_FILTER - 1)) begin
        fclk <= c_s2;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      fclk_q <= fclk;
      if (state == IDLE || fclk != fclk_q) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES - 1)) tcnt <= tcnt + 1'b1;
      BYTE_READY <= 1'b0;
      if (tout) state <= IDLE;
      else begin
        case (state)
          IDLE: if (fall && READ_ENABLE && !d_s2) begin
            state <= DATA;
            bitcnt <= '0;
          end
          DATA: if (fall) begin
            shreg <= {d_s2, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: if (fall) begin
            perr <= ~(^shreg ^ d_s2);
            state <= STOP;
          end
          STOP: if (fall) begin
            BYTE_READY <= 1'b1;
            BYTE_READ <= shreg;
            BYTE_ERROR_CODE <= {~d_s2, perr};
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb_ps2_mouse_receiver: directed PS/2 frames with a queue scoreboard checked on every BYTE_READY strobe
module tb_ps2_mouse_receiver;
  localparam int H = 50;
  logic CLK = 1'b0, RESET = 1'b0, READ_ENABLE = 1'b1, CLK_MOUSE_IN = 1'b1, DATA_MOUSE_IN = 1'b1;
  logic BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  int n_tests = 0, n_fail = 0, n_strobe = 0;
  logic prev_rdy = 1'b0;

  ps2_mouse_receiver dut (
    .CLK(CLK), .RESET(RESET), .READ_ENABLE(READ_ENABLE),
    .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BYTE_READY) begin
      n_strobe++;
      n_tests++;
      if (prev_rdy) begin
        n_fail++;
        $display("FAIL strobe_width: BYTE_READY high on consecutive cycles, required single-cycle pulse");
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got byte %h err %b, required no strobe", BYTE_READ, BYTE_ERROR_CODE);
      end else begin
        e = exp_q.pop_front();
        if ({BYTE_ERROR_CODE, BYTE_READ} !== e) begin
          n_fail++;
          $display("FAIL byte: got byte %h err %b, required byte %h err %b", BYTE_READ, BYTE_ERROR_CODE, e[7:0], e[9:8]);
        end
      end
    end
    prev_rdy = BYTE_READY;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic [1:0] err);
    exp_q.push_back({err, b});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
  endtask

  // bits lo..hi of {stop, parity, byte, start}, data set up while the mouse clock is high
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stp, input int lo, input int hi, input bit drop_re);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = lo; i <= hi; i++) begin
      DATA_MOUSE_IN = f[i];
      cycles(H);
      CLK_MOUSE_IN = 1'b0;
      cycles(H);
      CLK_MOUSE_IN = 1'b1;
      if (drop_re && i == 0) READ_ENABLE = 1'b0;
    end
    DATA_MOUSE_IN = 1'b1;
    cycles(4 * H);
  endtask

  task automatic frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits(b, par, stp, 0, 10, 1'b0);
  endtask

  initial begin
    cycles(5);
    #1;
    check("reset_ready", 32'(BYTE_READY), 32'd0);
    check("reset_byte", 32'(BYTE_READ), 32'd0);
    check("reset_err", 32'(BYTE_ERROR_CODE), 32'd0);
    RESET = 1'b1;
    cycles(20);
    // 1: clean 0xFA
    expect_byte(8'hFA, 2'b00);
    frame(8'hFA, 1'b1, 1'b1);
    cycles(100);
    #1;
    check("single_pulse", 32'(n_strobe), 32'd1);
    check("hold_byte", 32'(BYTE_READ), 32'hFA);
    check("hold_err", 32'(BYTE_ERROR_CODE), 32'd0);
    // 2: parity error, stop error
    expect_byte(8'hFA, 2'b01);
    frame(8'hFA, 1'b0, 1'b1);
    expect_byte(8'h00, 2'b10);
    frame(8'h00, 1'b1, 1'b0);
    // 3: truncated frame then timeout
    send_bits(8'hF4, 1'b0, 1'b1, 0, 4, 1'b0);
    cycles(6000);
    check("timeout_no_strobe", 32'(n_strobe), 32'd3);
    expect_byte(8'hF4, 2'b00);
    frame(8'hF4, 1'b0, 1'b1);
    // 4: short clock glitch with data low in IDLE
    DATA_MOUSE_IN = 1'b0;
    cycles(10);
    CLK_MOUSE_IN = 1'b0;
    cycles(3);
    CLK_MOUSE_IN = 1'b1;
    cycles(10);
    DATA_MOUSE_IN = 1'b1;
    cycles(50);
    expect_byte(8'h08, 2'b00);
    frame(8'h08, 1'b0, 1'b1);
    // 5: gated start, then enable dropped mid-frame
    READ_ENABLE = 1'b0;
    frame(8'hAA, 1'b1, 1'b1);
    check("gated_no_strobe", 32'(n_strobe), 32'd5);
    READ_ENABLE = 1'b1;
    cycles(20);
    expect_byte(8'h55, 2'b00);
    send_bits(8'h55, 1'b1, 1'b1, 0, 10, 1'b1);
    READ_ENABLE = 1'b1;
    cycles(20);
    // 6: asynchronous reset mid-frame
    send_bits(8'h3C, 1'b1, 1'b1, 0, 5, 1'b0);
    #3 RESET = 1'b0;
    #1;
    check("async_ready", 32'(BYTE_READY), 32'd0);
    check("async_byte", 32'(BYTE_READ), 32'd0);
    check("async_err", 32'(BYTE_ERROR_CODE), 32'd0);
    cycles(10);
    RESET = 1'b1;
    send_bits(8'h3C, 1'b1, 1'b1, 6, 10, 1'b0);
    cycles(6000);
    check("reset_rest_no_strobe", 32'(n_strobe), 32'd6);
    expect_byte(8'h3C, 2'b00);
    frame(8'h3C, 1'b1, 1'b1);
    cycles(100);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
